// File: rtl/dram_dqs_wr_seq_if.sv
// Write-command handshake between the controller write scheduler and the DQS write sequencer.
interface dram_dqs_wr_seq_if #(
  parameter int unsigned WL_W = 4
);
  logic            wr_cmd_valid;
  logic            wr_cmd_bl8;
  logic [WL_W-1:0] wl_cfg;
  logic            wr_cmd_ready;

  modport master (
    output wr_cmd_valid,
    output wr_cmd_bl8,
    output wl_cfg,
    input  wr_cmd_ready
  );

  modport slave (
    input  wr_cmd_valid,
    input  wr_cmd_bl8,
    input  wl_cfg,
    output wr_cmd_ready
  );
endinterface

// File: rtl/dram_dqs_wr_seq.sv
// Write-DQS sequencer for one DRAM byte lane: turns accepted write commands into the
// preamble/burst/postamble drive-enable and drive-data pattern for the DQS pad flops.
module dram_dqs_wr_seq #(
  parameter int unsigned WL_W    = 4,
  parameter int unsigned MAX_OUT = 2
) (
  input  logic             clk,
  input  logic             rst_l,
  dram_dqs_wr_seq_if.slave cmd,
  input  logic             channel_disabled,
  output logic             dram_io_drive_enable,
  output logic             dram_io_drive_data,
  output logic             busy,
  output logic             err_overlap
);

  localparam int unsigned      AGE_W   = WL_W + 2;
  localparam int unsigned      CMP_W   = AGE_W + 1;
  localparam int unsigned      CNT_W   = $clog2(MAX_OUT + 1);
  localparam logic [AGE_W-1:0] AGE_MAX = '1;
  localparam logic [WL_W-1:0]  WL_MIN  = WL_W'(2);

  logic [MAX_OUT-1:0] slot_vld_q, slot_vld_d;
  logic [MAX_OUT-1:0] slot_bl8_q, slot_bl8_d;
  logic [WL_W-1:0]    slot_wl_q  [MAX_OUT];
  logic [WL_W-1:0]    slot_wl_d  [MAX_OUT];
  logic [AGE_W-1:0]   slot_age_q [MAX_OUT];
  logic [AGE_W-1:0]   slot_age_d [MAX_OUT];

  logic [CMP_W-1:0]   slot_wl_x  [MAX_OUT];
  logic [CMP_W-1:0]   slot_b_x   [MAX_OUT];
  logic [CMP_W-1:0]   slot_age_x [MAX_OUT];

  logic               en_q, en_d;
  logic               data_q, data_d;
  logic               busy_q, busy_d;
  logic               err_pend_q, err_pend_d;
  logic               err_q, err_d;

  logic [CNT_W-1:0]   out_cnt_c;
  logic [WL_W-1:0]    new_wl_c;
  logic [CMP_W-1:0]   new_wl_x;
  logic [CMP_W-1:0]   new_b_x;
  logic               accept_c;
  logic               overlap_c;
  logic               placed_c;

  // Slot age counts edges since accept, so age == wl marks the preamble edge.
  for (genvar g = 0; g < MAX_OUT; g++) begin : g_slot_ext
    assign slot_wl_x[g]  = CMP_W'(slot_wl_q[g]);
    assign slot_b_x[g]   = slot_bl8_q[g] ? CMP_W'(4) : CMP_W'(2);
    assign slot_age_x[g] = CMP_W'(slot_age_q[g]);
  end

  always_comb begin
    out_cnt_c = '0;
    for (int i = 0; i < MAX_OUT; i++) begin
      out_cnt_c = out_cnt_c + CNT_W'(slot_vld_q[i]);
    end
  end

  // Disabled channel keeps ready high so the scheduler drains into the flush.
  assign cmd.wr_cmd_ready = rst_l & (channel_disabled | (out_cnt_c < CNT_W'(MAX_OUT)));

  assign new_wl_c = (cmd.wl_cfg < WL_MIN) ? WL_MIN : cmd.wl_cfg;
  assign new_wl_x = CMP_W'(new_wl_c);
  assign new_b_x  = cmd.wr_cmd_bl8 ? CMP_W'(4) : CMP_W'(2);
  assign accept_c = cmd.wr_cmd_valid & cmd.wr_cmd_ready & ~channel_disabled;

  // Burst windows relative to this edge: new [wl+1, wl+B], slot [wl-age+1, wl-age+B].
  always_comb begin
    overlap_c = 1'b0;
    for (int i = 0; i < MAX_OUT; i++) begin
      if (slot_vld_q[i] &&
          (new_wl_x + CMP_W'(1) + slot_age_x[i] <= slot_wl_x[i] + slot_b_x[i]) &&
          (slot_wl_x[i] + CMP_W'(1) <= new_wl_x + new_b_x + slot_age_x[i])) begin
        overlap_c = 1'b1;
      end
    end
  end

  always_comb begin
    slot_vld_d = slot_vld_q;
    slot_bl8_d = slot_bl8_q;
    slot_wl_d  = slot_wl_q;
    slot_age_d = slot_age_q;
    en_d       = 1'b0;
    data_d     = 1'b0;
    busy_d     = 1'b0;
    err_pend_d = 1'b0;
    err_d      = err_pend_q;
    placed_c   = 1'b0;

    for (int i = 0; i < MAX_OUT; i++) begin
      if (slot_vld_q[i]) begin
        if ((slot_age_x[i] >= slot_wl_x[i]) &&
            (slot_age_x[i] <= slot_wl_x[i] + slot_b_x[i] + CMP_W'(1))) begin
          en_d = 1'b1;
        end
        if ((slot_age_x[i] > slot_wl_x[i]) &&
            (slot_age_x[i] <= slot_wl_x[i] + slot_b_x[i])) begin
          data_d = 1'b1;
        end
        if (slot_age_x[i] == slot_wl_x[i] + slot_b_x[i] + CMP_W'(1)) begin
          slot_vld_d[i] = 1'b0;
        end
        if (slot_age_q[i] != AGE_MAX) begin
          slot_age_d[i] = slot_age_q[i] + AGE_W'(1);
        end
      end
    end

    busy_d = (|slot_vld_q) | en_d;

    if (accept_c && overlap_c) begin
      err_pend_d = 1'b1;
    end else if (accept_c) begin
      for (int i = 0; i < MAX_OUT; i++) begin
        if (!slot_vld_q[i] && !placed_c) begin
          placed_c      = 1'b1;
          slot_vld_d[i] = 1'b1;
          slot_bl8_d[i] = cmd.wr_cmd_bl8;
          slot_wl_d[i]  = new_wl_c;
          slot_age_d[i] = AGE_W'(1);
        end
      end
    end

    // Channel off wins over everything, including a burst in progress.
    if (channel_disabled) begin
      slot_vld_d = '0;
      en_d       = 1'b0;
      data_d     = 1'b0;
      busy_d     = 1'b0;
      err_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      slot_vld_q <= '0;
      slot_bl8_q <= '0;
      for (int i = 0; i < MAX_OUT; i++) begin
        slot_wl_q[i]  <= '0;
        slot_age_q[i] <= '0;
      end
      en_q       <= 1'b0;
      data_q     <= 1'b0;
      busy_q     <= 1'b0;
      err_pend_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      slot_vld_q <= slot_vld_d;
      slot_bl8_q <= slot_bl8_d;
      slot_wl_q  <= slot_wl_d;
      slot_age_q <= slot_age_d;
      en_q       <= en_d;
      data_q     <= data_d;
      busy_q     <= busy_d;
      err_pend_q <= err_pend_d;
      err_q      <= err_d;
    end
  end

  assign dram_io_drive_enable = en_q;
  assign dram_io_drive_data   = data_q;
  assign busy                 = busy_q;
  assign err_overlap          = err_q;

endmodule

// File: tb/tb_dram_dqs_wr_seq.sv
// Scoreboard bench for dram_dqs_wr_seq: a per-command timeline model predicts every cycle,
// a negedge monitor compares the DUT against the queued predictions.
module tb_dram_dqs_wr_seq;
  localparam int unsigned WL_W = 4;

  typedef struct { int t; int p; int b; int r; } cmd_t;
  typedef struct { int cyc; logic en; logic data; logic busy; logic err; } out_t;
  typedef struct { int cyc; logic rdy; } rdy_t;

  logic clk = 1'b0;
  logic rst_l;
  logic channel_disabled;
  logic en, data, busy, err;

  int   edge_cnt  = 0;
  int   checks    = 0;
  int   errors    = 0;
  int   drop_edge = -100;

  cmd_t cmds[$];
  out_t out_q[$];
  rdy_t rdy_q[$];
  out_t o_m;
  rdy_t r_m;

  dram_dqs_wr_seq_if #(.WL_W(WL_W)) cmd ();

  dram_dqs_wr_seq #(.WL_W(WL_W), .MAX_OUT(2)) dut (
    .clk                  (clk),
    .rst_l                (rst_l),
    .cmd                  (cmd),
    .channel_disabled     (channel_disabled),
    .dram_io_drive_enable (en),
    .dram_io_drive_data   (data),
    .busy                 (busy),
    .err_overlap          (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string nm, input int c, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0b expected=%0b", nm, c, got, exp);
    end
  endtask

  // Model: each kept command owns preamble p, burst p+1..p+b, postamble r=p+b+1.
  function automatic int n_active(int k);
    int n = 0;
    foreach (cmds[i]) if (cmds[i].t <= k && k < cmds[i].r) n++;
    return n;
  endfunction

  function automatic logic any_en(int c);
    foreach (cmds[i]) if (cmds[i].p <= c && c <= cmds[i].r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic any_data(int c);
    foreach (cmds[i]) if (cmds[i].p < c && c <= cmds[i].p + cmds[i].b) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic any_busy(int c);
    foreach (cmds[i]) if (cmds[i].t < c && c <= cmds[i].r) return 1'b1;
    return 1'b0;
  endfunction

  // Called #1 after an edge: drive inputs for the next edge and predict its outcome.
  task automatic step(input logic v, input logic b8, input logic [WL_W-1:0] wl, input logic dis);
    int   e, ne, wle, bb, pn;
    logic rdy, ovl;
    rdy_t re;
    out_t oe;
    cmd_t nc;
    e  = edge_cnt;
    ne = e + 1;
    cmd.wr_cmd_valid = v;
    cmd.wr_cmd_bl8   = b8;
    cmd.wl_cfg       = wl;
    channel_disabled = dis;
    rdy    = dis || (n_active(e) < 2);
    re.cyc = e;
    re.rdy = rdy;
    rdy_q.push_back(re);
    oe.cyc = ne;
    oe.err = (drop_edge == e);
    if (dis) begin
      cmds.delete();
    end else if (v && rdy) begin
      wle = (int'(wl) < 2) ? 2 : int'(wl);
      bb  = b8 ? 4 : 2;
      pn  = ne + wle;
      ovl = 1'b0;
      foreach (cmds[i]) begin
        if (cmds[i].p + 1 <= pn + bb && pn + 1 <= cmds[i].p + cmds[i].b) ovl = 1'b1;
      end
      if (ovl) begin
        drop_edge = ne;
      end else begin
        nc.t = ne; nc.p = pn; nc.b = bb; nc.r = pn + bb + 1;
        cmds.push_back(nc);
      end
    end
    oe.en   = any_en(ne);
    oe.data = any_data(ne);
    oe.busy = any_busy(ne);
    out_q.push_back(oe);
    while (cmds.size() > 0 && cmds[0].r < e) void'(cmds.pop_front());
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic reset_pulse();
    #2;
    rst_l = 1'b0;
    #1;
    chk("async_rst_enable", edge_cnt, en, 1'b0);
    chk("async_rst_data", edge_cnt, data, 1'b0);
    chk("async_rst_busy", edge_cnt, busy, 1'b0);
    chk("async_rst_ready", edge_cnt, cmd.wr_cmd_ready, 1'b0);
    rdy_q.delete();
    out_q.delete();
    cmds.delete();
    drop_edge = -100;
    cmd.wr_cmd_valid = 1'b0;
    channel_disabled = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_l = 1'b1;
  endtask

  always @(negedge clk) begin
    if (rdy_q.size() > 0 && rdy_q[0].cyc == edge_cnt) begin
      r_m = rdy_q.pop_front();
      chk("ready", edge_cnt, cmd.wr_cmd_ready, r_m.rdy);
    end
    if (out_q.size() > 0 && out_q[0].cyc == edge_cnt) begin
      o_m = out_q.pop_front();
      chk("drive_enable", edge_cnt, en, o_m.en);
      chk("drive_data", edge_cnt, data, o_m.data);
      chk("busy", edge_cnt, busy, o_m.busy);
      chk("err_overlap", edge_cnt, err, o_m.err);
    end
  end

  initial begin
    logic             v, b8, dis;
    logic [WL_W-1:0]  wl;
    int               dis_left;
    rst_l            = 1'b0;
    channel_disabled = 1'b0;
    cmd.wr_cmd_valid = 1'b0;
    cmd.wr_cmd_bl8   = 1'b0;
    cmd.wl_cfg       = '0;
    dis_left         = 0;
    #3;
    chk("reset_enable", edge_cnt, en, 1'b0);
    chk("reset_data", edge_cnt, data, 1'b0);
    chk("reset_busy", edge_cnt, busy, 1'b0);
    chk("reset_err", edge_cnt, err, 1'b0);
    chk("reset_ready", edge_cnt, cmd.wr_cmd_ready, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst_l = 1'b1;

    // Lone BL4, wl 3
    step(1'b1, 1'b0, 4'd3, 1'b0);
    idle(10);
    // Seamless BL8 pair, wl 2
    step(1'b1, 1'b1, 4'd2, 1'b0);
    idle(3);
    step(1'b1, 1'b1, 4'd2, 1'b0);
    idle(14);
    // Burst overlap: BL8 then BL4 two cycles later, wl 4
    step(1'b1, 1'b1, 4'd4, 1'b0);
    idle(1);
    step(1'b1, 1'b0, 4'd4, 1'b0);
    idle(12);
    // Back-pressure at wl 15 with valid held high
    step(1'b1, 1'b0, 4'd15, 1'b0);
    idle(1);
    for (int i = 0; i < 22; i++) step(1'b1, 1'b0, 4'd15, 1'b0);
    idle(40);
    // Channel disable mid-burst, then a command while still disabled
    step(1'b1, 1'b1, 4'd2, 1'b0);
    idle(3);
    step(1'b1, 1'b1, 4'd2, 1'b0);
    step(1'b0, 1'b0, 4'd2, 1'b1);
    step(1'b0, 1'b0, 4'd2, 1'b1);
    step(1'b1, 1'b0, 4'd3, 1'b1);
    idle(12);
    // Async reset mid-burst, then the lone BL4 again
    step(1'b1, 1'b1, 4'd2, 1'b0);
    idle(4);
    reset_pulse();
    step(1'b1, 1'b0, 4'd3, 1'b0);
    idle(10);
    // Latency clamp and mixed latencies
    step(1'b1, 1'b1, 4'd0, 1'b0);
    idle(2);
    step(1'b1, 1'b0, 4'd5, 1'b0);
    idle(12);

    for (int i = 0; i < 1500; i++) begin
      v  = ($urandom_range(99) < 35);
      b8 = 1'($urandom_range(1));
      wl = ($urandom_range(3) == 0) ? WL_W'($urandom_range(15)) : WL_W'($urandom_range(5));
      if (dis_left > 0) dis_left--;
      else if ($urandom_range(149) == 0) dis_left = int'($urandom_range(4, 1));
      dis = (dis_left > 0);
      step(v, b8, wl, dis);
    end
    idle(25);
    @(negedge clk);
    #1;
    if (out_q.size() != 0 || rdy_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain pending_out=%0d pending_ready=%0d expected=0",
               out_q.size(), rdy_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
